// File: rtl/param_frame_rx.sv
// param_frame_rx: synchronizes an asynchronous byte-strobe pin interface, assembles an
// 8-byte frame into two signed 32-bit coefficients and issues a one-cycle start pulse.
`default_nettype none

module param_frame_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  data_in,
  input  logic        stb_in,
  input  logic        sof_in,
  input  logic        core_busy,
  output logic [31:0] a0,
  output logic [31:0] a1,
  output logic        start_calc,
  output logic        loader_busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } state_t;

  // Each stage carries {sof, stb, data}; stage 0 is nearest the pins.
  logic [SYNC_STAGES-1:0][9:0] sync_q, sync_d;
  logic                        stb_prev_q, stb_prev_d;
  state_t                      state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [63:0]                 asm_q, asm_d;
  logic [31:0]                 a0_q, a0_d;
  logic [31:0]                 a1_q, a1_d;
  logic                        start_q, start_d;
  logic                        ovr_q, ovr_d;

  logic [7:0] byte_s;
  logic       stb_s;
  logic       sof_s;
  logic       stb_edge;

  assign byte_s   = sync_q[SYNC_STAGES-1][7:0];
  assign stb_s    = sync_q[SYNC_STAGES-1][8];
  assign sof_s    = sync_q[SYNC_STAGES-1][9];
  assign stb_edge = stb_s & ~stb_prev_q;

  // The edge register runs regardless of ena so re-enabling cannot see a stale edge.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], {sof_in, stb_in, data_in}};
    stb_prev_d = stb_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    start_d = 1'b0;
    ovr_d   = ovr_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (stb_edge) begin
            asm_d[7:0] = byte_s;
            cnt_d      = 3'd1;
            state_d    = COLLECT;
            if (sof_s) ovr_d = 1'b0;
          end
        end
        COLLECT: begin
          if (stb_edge) begin
            if (sof_s) begin
              // Resync: abandon the partial frame and restart at slot 0.
              asm_d[7:0] = byte_s;
              cnt_d      = 3'd1;
              ovr_d      = 1'b0;
            end else begin
              asm_d[{cnt_q, 3'b000} +: 8] = byte_s;
              cnt_d = 3'(cnt_q + 3'd1);
              if (cnt_q == 3'd7) state_d = PENDING;
            end
          end
        end
        PENDING: begin
          if (stb_edge) ovr_d = 1'b1;
          if (!core_busy) begin
            a0_d    = asm_q[31:0];
            a1_d    = asm_q[63:32];
            start_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      stb_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      asm_q      <= 64'd0;
      a0_q       <= 32'd0;
      a1_q       <= 32'd0;
      start_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      stb_prev_q <= stb_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      a0_q       <= a0_d;
      a1_q       <= a1_d;
      start_q    <= start_d;
      ovr_q      <= ovr_d;
    end
  end

  assign a0          = a0_q;
  assign a1          = a1_q;
  assign start_calc  = start_q;
  assign loader_busy = (state_q != IDLE);
  assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_param_frame_rx.sv
// tb_param_frame_rx: randomized and directed stimulus for param_frame_rx, checked every
// cycle against a frame-level reference model plus literal expectations.
`default_nettype none

module tb_param_frame_rx;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  data_in = 8'd0;
  logic        stb_in = 1'b0;
  logic        sof_in = 1'b0;
  logic        core_busy = 1'b0;
  logic [31:0] a0, a1;
  logic        start_calc, loader_busy, overrun;

  param_frame_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .stb_in(stb_in),
    .sof_in(sof_in), .core_busy(core_busy), .a0(a0), .a1(a1),
    .start_calc(start_calc), .loader_busy(loader_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Reference model: pin history, list of bytes of the frame in progress, pending word.
  logic [9:0]  hq[$];
  logic [7:0]  mf[$];
  logic        m_pend = 1'b0;
  logic [63:0] m_word = 64'd0;
  logic [31:0] m_a0 = 32'd0, m_a1 = 32'd0;
  logic        m_start = 1'b0, m_ovr = 1'b0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       e, sf;
    logic [7:0] d;
    m_start = 1'b0;
    if (!rst_n) begin
      hq = {};
      for (int i = 0; i < SYNC + 2; i++) hq.push_back(10'd0);
      mf = {};
      m_pend = 1'b0; m_word = 64'd0; m_a0 = 32'd0; m_a1 = 32'd0; m_ovr = 1'b0;
      return;
    end
    hq.push_front({sof_in, stb_in, data_in});
    void'(hq.pop_back());
    // A pin rise first sampled SYNC edges ago is the byte taken at this edge.
    e  = hq[SYNC][8] && !hq[SYNC+1][8];
    sf = hq[SYNC][9];
    d  = hq[SYNC][7:0];
    if (!ena) return;
    if (m_pend) begin
      if (e) m_ovr = 1'b1;
      if (!core_busy) begin
        m_a0 = m_word[31:0];
        m_a1 = m_word[63:32];
        m_start = 1'b1;
        m_pend = 1'b0;
      end
    end else if (e) begin
      if (sf) begin
        mf = {};
        m_ovr = 1'b0;
      end
      mf.push_back(d);
      if (mf.size() == 8) begin
        for (int i = 0; i < 8; i++) m_word[8*i +: 8] = mf[i];
        mf = {};
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    logic exp_busy;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      exp_busy = m_pend || (mf.size() != 0);
      check("cycle_outputs", {a0, a1, start_calc, loader_busy, overrun},
            {m_a0, m_a1, m_start, exp_busy, m_ovr});
      if (start_calc === 1'b1) pulses++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Honours the host timing window: data/sof settle before the rise and hold past it.
  task automatic send_byte(input logic [7:0] b, input logic s);
    data_in = b;
    sof_in  = s;
    cyc(SYNC + 1 + int'($urandom_range(0, 2)));
    stb_in = 1'b1;
    cyc(SYNC + 1 + int'($urandom_range(0, 2)));
    stb_in = 1'b0;
    cyc(SYNC + 1);
  endtask

  task automatic send_bytes(input logic [63:0] w, input int first, input int last,
                            input logic first_sof);
    for (int i = first; i <= last; i++) send_byte(w[8*i +: 8], (i == first) ? first_sof : 1'b0);
  endtask

  initial begin
    int          p0;
    logic [63:0] w1, w2;
    fork
      monitor();
    join_none

    cyc(3);
    check("reset_outputs", {a0, a1, start_calc, loader_busy, overrun}, 67'd0);
    rst_n = 1'b1;
    cyc(2);

    // Nominal frame
    p0 = pulses;
    send_bytes(64'hDEADBEEF_12345678, 0, 7, 1'b1);
    cyc(6);
    check("nominal_a0", a0, 32'h12345678);
    check("nominal_a1", a1, 32'hDEADBEEF);
    check("nominal_a1_negative", ($signed(a1) < 0), 1);
    check("nominal_model_a1", m_a1, 32'hDEADBEEF);
    check("nominal_pulses", pulses - p0, 1);

    // Busy hold-off with one extra strobe while pending
    core_busy = 1'b1;
    p0 = pulses;
    send_bytes(64'h0BADF00D_CAFEBABE, 0, 7, 1'b1);
    send_byte(8'h99, 1'b0);
    cyc(5);
    check("busy_no_pulse", pulses - p0, 0);
    check("busy_loader_busy", loader_busy, 1);
    check("busy_overrun", overrun, 1);
    core_busy = 1'b0;
    cyc(4);
    check("busy_release_pulse", pulses - p0, 1);
    check("busy_words", {a1, a0}, 64'h0BADF00D_CAFEBABE);
    check("busy_overrun_sticky", overrun, 1);
    send_byte(8'h11, 1'b1);
    check("overrun_cleared_by_sof", overrun, 0);
    send_bytes(64'h0, 1, 7, 1'b0);
    cyc(6);

    // Resync mid-frame
    p0 = pulses;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_bytes(64'h08070605_04030201, 0, 7, 1'b1);
    cyc(6);
    check("resync_a0", a0, 32'h04030201);
    check("resync_a1", a1, 32'h08070605);
    check("resync_pulses", pulses - p0, 1);

    // Enable gating across two strobes
    p0 = pulses;
    send_bytes(64'h44332211_DDCCBBAA, 0, 3, 1'b1);
    ena = 1'b0;
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b1);
    ena = 1'b1;
    check("ena_still_collecting", loader_busy, 1);
    send_bytes(64'h44332211_DDCCBBAA, 4, 7, 1'b0);
    cyc(6);
    check("ena_words", {a1, a0}, 64'h44332211_DDCCBBAA);
    check("ena_pulses", pulses - p0, 1);

    // Back-to-back frames
    p0 = pulses;
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    send_bytes(w1, 0, 7, 1'b1);
    cyc(4);
    check("b2b_first", {a1, a0}, w1);
    send_bytes(w2, 0, 6, 1'b1);
    check("b2b_hold", {a1, a0}, w1);
    send_byte(w2[63:56], 1'b0);
    cyc(4);
    check("b2b_second", {a1, a0}, w2);
    check("b2b_pulses", pulses - p0, 2);

    // Reset mid-frame; next byte without sof is byte 0
    send_bytes(64'h0, 0, 2, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    check("midframe_reset_outputs", {a0, a1, start_calc, loader_busy, overrun}, 67'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    send_bytes(64'h28272625_24232221, 0, 7, 1'b0);
    cyc(6);
    check("post_reset_words", {a1, a0}, 64'h28272625_24232221);

    // Randomized traffic: random sof, enable drops and busy periods
    for (int n = 0; n < 160; n++) begin
      ena       = ($urandom_range(0, 99) >= 12);
      core_busy = ($urandom_range(0, 99) < 30);
      send_byte(8'($urandom), ($urandom_range(0, 99) < 10));
    end
    ena = 1'b1;
    core_busy = 1'b0;
    cyc(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
